// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one line-wide memory port between
//            the icache miss path and the dcache miss/writeback path.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rqst_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_data_ready_o,
    output logic [LINE_W-1:0] ic_data_o,
    output logic [ADDR_W-1:0] ic_addr_o,
    input  logic              dc_rqst_i,
    input  logic              dc_wr_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_data_ready_o,
    output logic [LINE_W-1:0] dc_data_o,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~{{(ADDR_W-4){1'b0}}, 4'hF};

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1 = dcache held the previous grant
    logic              gnt_d_q, gnt_d_d;     // 1 = current transaction is the dcache's
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_data_q, ic_data_d;
    logic [ADDR_W-1:0] ic_addr_q, ic_addr_d;
    logic [LINE_W-1:0] dc_data_q, dc_data_d;
    logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
    logic              pick_d;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        gnt_d_d   = gnt_d_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        ic_data_d = ic_data_q;
        ic_addr_d = ic_addr_q;
        dc_data_d = dc_data_q;
        dc_addr_d = dc_addr_q;
        // dcache wins when alone, or on a conflict when icache went last
        pick_d    = dc_rqst_i && (!ic_rqst_i || !last_d_q);

        case (state_q)
            IDLE: begin
                if (ic_rqst_i || dc_rqst_i) begin
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    addr_d   = (pick_d ? dc_addr_i : ic_addr_i) & LINE_MASK;
                    we_d     = pick_d && dc_wr_i;
                    wdata_d  = (pick_d && dc_wr_i) ? dc_wdata_i : '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    if (gnt_d_q) begin
                        dc_addr_d = addr_q;
                        if (!we_q) begin
                            dc_data_d = mem_rdata_i;
                        end
                    end else begin
                        ic_addr_d = addr_q;
                        ic_data_d = mem_rdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            gnt_d_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ic_data_q <= '0;
            ic_addr_q <= '0;
            dc_data_q <= '0;
            dc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            gnt_d_q   <= gnt_d_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            ic_data_q <= ic_data_d;
            ic_addr_q <= ic_addr_d;
            dc_data_q <= dc_data_d;
            dc_addr_q <= dc_addr_d;
        end
    end

    assign mem_req_o       = (state_q == BUSY);
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign busy_o          = (state_q != IDLE);
    assign ic_data_ready_o = (state_q == RESP) && !gnt_d_q;
    assign dc_data_ready_o = (state_q == RESP) &&  gnt_d_q;
    assign ic_data_o       = ic_data_q;
    assign ic_addr_o       = ic_addr_q;
    assign dc_data_o       = dc_data_q;
    assign dc_addr_o       = dc_addr_q;

endmodule
`default_nettype wire
